stock_price_table_ctrl: RTL and testbench
=========================================

STOCK_PRICE_TABLE_CTRL -- requirements
Module: stock_price_table_ctrl

Interface
REQ-001 SHALL have ports: axis_aclk  in  1  sole clock, all logic rising-edge.
REQ-002 SHALL have: axis_resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: upd_valid in 1, upd_ready out 1, upd_index in 9, upd_price in 32, upd_vol_delta in 16: market-feed update channel.
REQ-004 SHALL have: lkp_valid in 1, lkp_ready out 1, lkp_index in 9: lookup request channel.
REQ-005 SHALL have: lkp_rsp_valid out 1, lkp_rsp_ready in 1, lkp_rsp_hit out 1, lkp_rsp_price out 32, lkp_rsp_vol out 16: lookup response channel.
REQ-006 SHALL have: clear_req in 1 (pulse, start table wipe), clear_busy out 1.
REQ-007 SHALL have RAM master port: ram_addr out 9, ram_din out 49, ram_we out 1, ram_dout in 49; single-port 512x49 RAM with 1-cycle registered read, write-first.
REQ-008 SHALL have: lkp_miss_cnt out 32: lookups returning hit=0.
REQ-009 Entry format SHALL be {valid[48], price[47:16], volume[15:0]}.

Function
REQ-010 FSM states SHALL be IDLE, RD, EVAL, WR, RSP, CLR.
REQ-011 ram_addr, ram_din, ram_we SHALL be registered outputs.
REQ-012 upd_ready SHALL be 1 only in IDLE with no clear pending.
REQ-013 lkp_ready SHALL be 1 only in IDLE with no clear pending and upd_valid=0 (update priority over lookup).
REQ-014 Priority in IDLE SHALL be: pending clear > update > lookup.
REQ-015 Handshake (valid&ready at edge N) SHALL capture index/payload, load ram_addr=index, ram_we=0, enter RD.
REQ-016 RD SHALL last 1 cycle; EVAL SHALL sample ram_dout (valid in that cycle).
REQ-017 Update in EVAL: new entry SHALL be {1, upd_price, vol}; vol = old.volume+delta saturated at 16'hFFFF if old.valid=1, else delta; register ram_we=1, ram_din=entry; enter WR.
REQ-018 WR SHALL last 1 cycle (write committed at its end), then ram_we=0, return to IDLE; update occupancy 4 cycles accept-to-IDLE.
REQ-019 Lookup in EVAL SHALL register lkp_rsp_hit=old.valid, price/vol fields from ram_dout, lkp_rsp_valid=1; enter RSP.
REQ-020 Response SHALL hold stable while lkp_rsp_valid=1 and lkp_rsp_ready=0; on handshake clear lkp_rsp_valid, return to IDLE.
REQ-021 lkp_miss_cnt SHALL increment by 1 at EVAL of a lookup with hit=0; wraps modulo 2^32.
REQ-022 clear_req SHALL set a pending flag in any state; ignored while clear_busy=1.
REQ-023 Pending clear SHALL be started only from IDLE (in-flight update/lookup completes first, including RSP handshake).
REQ-024 CLR SHALL write 49'h0 to addresses 0..511 ascending, one per cycle (ram_we=1), 512 write cycles, then ram_we=0, IDLE.
REQ-025 clear_busy SHALL be 1 from cycle after clear_req acceptance (pending) through last CLR write; 0 otherwise.
REQ-026 Address counter SHALL not wrap past 511 in CLR; index values are always in range (9 bits).
REQ-027 Simultaneous upd_valid, lkp_valid, clear_req in IDLE: clear taken, both ready=0 that cycle.

Reset
REQ-028 axis_resetn=0 SHALL immediately force: state IDLE, upd_ready=0, lkp_ready=0, lkp_rsp_valid=0, lkp_rsp_hit=0, lkp_rsp_price=0, lkp_rsp_vol=0, ram_we=0, ram_addr=0, ram_din=0, clear_busy=0, clear pending=0, lkp_miss_cnt=0.
REQ-029 Reset mid-WR or mid-CLR SHALL abort with ram_we=0; RAM contents not cleared by reset.
REQ-030 First handshake SHALL be possible first cycle after reset deassertion.

Verification
REQ-031 Clear, then lookup index 5 -> hit=0, price=0, vol=0, lkp_miss_cnt=1.
REQ-032 Update idx 5 price 0x00001234 delta 10, then delta 7 -> lookup idx 5 returns hit=1, price 0x1234, vol 17; RAM written twice, 4 cycles each.
REQ-033 Update idx 9 delta 0xFFF0 twice -> vol=0xFFFF (saturated).
REQ-034 Lookup with lkp_rsp_ready=0 for 20 cycles, upd_valid asserted meanwhile -> response stable, upd_ready=0 until response handshake.
REQ-035 clear_req during RSP -> clear starts after response handshake; exactly 512 writes, addresses 0..511; clear_busy high throughout.
REQ-036 axis_resetn low during CLR at address 100 -> all outputs at reset values same cycle; ram_we=0.

Source files
------------

// File: rtl/stock_price_table_ctrl.sv
// Stock price table controller: serialises market-feed updates, lookups and
// full-table wipes onto a single-port 512x49 RAM ({valid, price, volume}).
module stock_price_table_ctrl (
  input  logic        axis_aclk,
  input  logic        axis_resetn,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [8:0]  upd_index,
  input  logic [31:0] upd_price,
  input  logic [15:0] upd_vol_delta,
  input  logic        lkp_valid,
  output logic        lkp_ready,
  input  logic [8:0]  lkp_index,
  output logic        lkp_rsp_valid,
  input  logic        lkp_rsp_ready,
  output logic        lkp_rsp_hit,
  output logic [31:0] lkp_rsp_price,
  output logic [15:0] lkp_rsp_vol,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic [8:0]  ram_addr,
  output logic [48:0] ram_din,
  output logic        ram_we,
  input  logic [48:0] ram_dout,
  output logic [31:0] lkp_miss_cnt
);

  typedef enum logic [2:0] {IDLE, RD, EVAL, WR, RSP, CLR} state_t;

  state_t      state_q, state_d;
  logic        op_upd_q, op_upd_d;
  logic [31:0] price_q, price_d;
  logic [15:0] delta_q, delta_d;
  logic [8:0]  ram_addr_q, ram_addr_d;
  logic [48:0] ram_din_q, ram_din_d;
  logic        ram_we_q, ram_we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_hit_q, rsp_hit_d;
  logic [31:0] rsp_price_q, rsp_price_d;
  logic [15:0] rsp_vol_q, rsp_vol_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic [31:0] miss_q, miss_d;

  logic clr_acc_s, clr_go_s, idle_s, upd_ready_s, lkp_ready_s;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A new clear request is only honoured while no wipe is pending or running.
  assign clr_acc_s   = clear_req && !busy_q;
  assign idle_s      = (state_q == IDLE);
  assign clr_go_s    = idle_s && (pend_q || clr_acc_s);
  assign upd_ready_s = axis_resetn && idle_s && !pend_q && !clr_acc_s;
  assign lkp_ready_s = upd_ready_s && !upd_valid;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    op_upd_d    = op_upd_q;
    price_d     = price_q;
    delta_d     = delta_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = ram_we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_price_d = rsp_price_q;
    rsp_vol_d   = rsp_vol_q;
    pend_d      = pend_q;
    busy_d      = busy_q;
    miss_d      = miss_q;

    if (clr_acc_s) begin
      pend_d = 1'b1;
      busy_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (clr_go_s) begin
          pend_d     = 1'b0;
          ram_we_d   = 1'b1;
          ram_addr_d = 9'd0;
          ram_din_d  = 49'h0;
          state_d    = CLR;
        end else if (upd_valid && upd_ready_s) begin
          op_upd_d   = 1'b1;
          price_d    = upd_price;
          delta_d    = upd_vol_delta;
          ram_addr_d = upd_index;
          ram_we_d   = 1'b0;
          state_d    = RD;
        end else if (lkp_valid && lkp_ready_s) begin
          op_upd_d   = 1'b0;
          ram_addr_d = lkp_index;
          ram_we_d   = 1'b0;
          state_d    = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: state_d = EVAL;
      EVAL: begin
        if (op_upd_q) begin
          ram_din_d = {1'b1, price_q,
                       ram_dout[48] ? sat_add16(ram_dout[15:0], delta_q) : delta_q};
          ram_we_d  = 1'b1;
          state_d   = WR;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = ram_dout[48];
          rsp_price_d = ram_dout[47:16];
          rsp_vol_d   = ram_dout[15:0];
          if (!ram_dout[48]) begin
            miss_d = miss_q + 32'd1;
          end else begin
            miss_d = miss_q;
          end
          state_d = RSP;
        end
      end
      WR: begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
      RSP: begin
        if (lkp_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      CLR: begin
        // Stop at the top address instead of wrapping back to 0.
        if (ram_addr_q == 9'd511) begin
          ram_we_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          ram_addr_d = ram_addr_q + 9'd1;
        end
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= IDLE;
      op_upd_q    <= 1'b0;
      price_q     <= 32'h0;
      delta_q     <= 16'h0;
      ram_addr_q  <= 9'd0;
      ram_din_q   <= 49'h0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_price_q <= 32'h0;
      rsp_vol_q   <= 16'h0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      miss_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_upd_q    <= op_upd_d;
      price_q     <= price_d;
      delta_q     <= delta_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_price_q <= rsp_price_d;
      rsp_vol_q   <= rsp_vol_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      miss_q      <= miss_d;
    end
  end

  assign upd_ready     = upd_ready_s;
  assign lkp_ready     = lkp_ready_s;
  assign lkp_rsp_valid = rsp_valid_q;
  assign lkp_rsp_hit   = rsp_hit_q;
  assign lkp_rsp_price = rsp_price_q;
  assign lkp_rsp_vol   = rsp_vol_q;
  assign clear_busy    = busy_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign ram_we        = ram_we_q;
  assign lkp_miss_cnt  = miss_q;

endmodule

// File: tb/tb_stock_price_table_ctrl.sv
// Self-checking bench for stock_price_table_ctrl with a behavioural RAM and a
// table-level reference model.
module tb_stock_price_table_ctrl;

  logic        axis_aclk = 1'b0;
  logic        axis_resetn = 1'b1;
  logic        upd_valid = 1'b0, upd_ready;
  logic [8:0]  upd_index = 9'd0;
  logic [31:0] upd_price = 32'h0;
  logic [15:0] upd_vol_delta = 16'h0;
  logic        lkp_valid = 1'b0, lkp_ready;
  logic [8:0]  lkp_index = 9'd0;
  logic        lkp_rsp_valid, lkp_rsp_ready = 1'b0, lkp_rsp_hit;
  logic [31:0] lkp_rsp_price;
  logic [15:0] lkp_rsp_vol;
  logic        clear_req = 1'b0, clear_busy;
  logic [8:0]  ram_addr;
  logic [48:0] ram_din, ram_dout;
  logic        ram_we;
  logic [31:0] lkp_miss_cnt;

  int errors = 0;
  int checks = 0;

  stock_price_table_ctrl dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_price(upd_price), .upd_vol_delta(upd_vol_delta),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index),
    .lkp_rsp_valid(lkp_rsp_valid), .lkp_rsp_ready(lkp_rsp_ready),
    .lkp_rsp_hit(lkp_rsp_hit), .lkp_rsp_price(lkp_rsp_price), .lkp_rsp_vol(lkp_rsp_vol),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .lkp_miss_cnt(lkp_miss_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  // Single-port RAM, registered read, write-first.
  logic [48:0] mem [512];
  always @(posedge axis_aclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  int wr_cnt = 0;
  always @(negedge axis_aclk) if (ram_we === 1'b1) wr_cnt++;

  // Reference model of the table contents.
  bit          m_valid [512];
  logic [31:0] m_price [512];
  logic [15:0] m_vol   [512];
  logic [31:0] m_miss = 32'h0;

  task automatic model_clear_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      m_valid[i] = 1'b0; m_price[i] = 32'h0; m_vol[i] = 16'h0;
    end
  endtask

  task automatic model_update(input int idx, input logic [31:0] p, input logic [15:0] d);
    int unsigned s;
    if (m_valid[idx]) begin
      s = m_vol[idx];
      s = s + d;
      m_vol[idx] = (s > 32'd65535) ? 16'hFFFF : s[15:0];
    end else begin
      m_vol[idx] = d;
    end
    m_valid[idx] = 1'b1;
    m_price[idx] = p;
  endtask

  task automatic do_update(input logic [8:0] idx, input logic [31:0] p, input logic [15:0] d,
                           output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; n = 0;
    @(negedge axis_aclk);
    upd_valid = 1'b1; upd_index = idx; upd_price = p; upd_vol_delta = d;
    #1;
    while (upd_ready !== 1'b1 && n < 2000) begin @(negedge axis_aclk); #1; n++; end
    if (n >= 2000) begin to = 1'b1; upd_valid = 1'b0; return; end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    upd_valid = 1'b0;
    lat = 1;
    #1;
    while (upd_ready !== 1'b1 && lat < 2000) begin @(negedge axis_aclk); #1; lat++; end
    if (lat >= 2000) to = 1'b1;
  endtask

  task automatic do_lookup(input logic [8:0] idx, input int stall,
                           output logic hit, output logic [31:0] p, output logic [15:0] v,
                           output bit to);
    int n;
    to = 1'b0; n = 0; hit = 1'b0; p = 32'h0; v = 16'h0;
    @(negedge axis_aclk);
    lkp_valid = 1'b1; lkp_index = idx; lkp_rsp_ready = 1'b0;
    #1;
    while (lkp_ready !== 1'b1 && n < 2000) begin @(negedge axis_aclk); #1; n++; end
    if (n >= 2000) begin to = 1'b1; lkp_valid = 1'b0; return; end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_valid = 1'b0;
    n = 0;
    #1;
    while (lkp_rsp_valid !== 1'b1 && n < 50) begin @(negedge axis_aclk); #1; n++; end
    if (n >= 50) begin to = 1'b1; return; end
    hit = lkp_rsp_hit; p = lkp_rsp_price; v = lkp_rsp_vol;
    repeat (stall) @(negedge axis_aclk);
    lkp_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_rsp_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge axis_aclk); clear_req = 1'b1;
    @(negedge axis_aclk); clear_req = 1'b0;
  endtask

  // Called at a falling edge; follows one wipe to its end and tallies anomalies.
  task automatic watch_clear(output int nw, output int bad, output int busy_low, output bit to);
    nw = 0; bad = 0; busy_low = 0; to = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      #1;
      if (ram_we === 1'b1) begin
        if (ram_addr !== nw[8:0] || ram_din !== 49'h0) bad++;
        if (clear_busy !== 1'b1) busy_low++;
        nw++;
      end else if (nw > 0) begin
        to = 1'b0;
        break;
      end
      @(negedge axis_aclk);
    end
  endtask

  task automatic test_reset();
    axis_resetn = 1'b1;
    #2 axis_resetn = 1'b0;
    repeat (2) @(negedge axis_aclk);
    #1;
    checks++;
    if ({upd_ready, lkp_ready, lkp_rsp_valid, lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol,
         ram_we, ram_addr, ram_din, clear_busy, lkp_miss_cnt} !== 144'h0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0", {upd_ready, lkp_ready, lkp_rsp_valid,
               lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol, ram_we, ram_addr, ram_din, clear_busy, lkp_miss_cnt});
    end
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    m_miss = 32'h0;
  endtask

  task automatic check_clear_result(input string tag, input int nw, input int bad,
                                    input int busy_low, input bit to);
    checks++;
    if (to || nw != 512) begin errors++; $display("FAIL %s_write_count: got %0d (timeout=%0d) required 512", tag, nw, to); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_addr_data: got %0d bad writes required 0", tag, bad); end
    checks++;
    if (busy_low != 0) begin errors++; $display("FAIL %s_busy_during: got %0d low cycles required 0", tag, busy_low); end
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b required 0", tag, clear_busy); end
  endtask

  task automatic test_clear_then_lookup();
    int nw, bad, bl; bit to; logic h; logic [31:0] p; logic [15:0] v;
    pulse_clear();
    watch_clear(nw, bad, bl, to);
    check_clear_result("clear", nw, bad, bl, to);
    model_clear_range(0, 511);
    do_lookup(9'd5, 0, h, p, v, to);
    if (!m_valid[5]) m_miss++;
    checks++;
    if (to || {h, p, v} !== {1'b0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL clear_lookup5: got hit=%b price=%h vol=%h required 0/0/0", h, p, v);
    end
    checks++;
    if (lkp_miss_cnt !== 32'd1) begin errors++; $display("FAIL clear_miss_cnt: got %0d required 1", lkp_miss_cnt); end
  endtask

  task automatic test_update_accumulate();
    int lat1, lat2, w0; bit t1, t2, to; logic h; logic [31:0] p; logic [15:0] v;
    w0 = wr_cnt;
    do_update(9'd5, 32'h00001234, 16'd10, lat1, t1); model_update(5, 32'h00001234, 16'd10);
    do_update(9'd5, 32'h00001234, 16'd7,  lat2, t2); model_update(5, 32'h00001234, 16'd7);
    checks++;
    if (t1 || t2 || lat1 != 4 || lat2 != 4) begin
      errors++; $display("FAIL upd_latency: got %0d,%0d required 4,4", lat1, lat2);
    end
    checks++;
    if (wr_cnt - w0 != 2) begin errors++; $display("FAIL upd_write_count: got %0d required 2", wr_cnt - w0); end
    do_lookup(9'd5, 0, h, p, v, to);
    checks++;
    if (to || {h, p, v} !== {1'b1, 32'h00001234, 16'd17}) begin
      errors++; $display("FAIL accum_lookup5: got hit=%b price=%h vol=%0d required 1/1234/17", h, p, v);
    end
  endtask

  task automatic test_saturation();
    int lat; bit to; logic h; logic [31:0] p; logic [15:0] v;
    do_update(9'd9, 32'hCAFE0009, 16'hFFF0, lat, to); model_update(9, 32'hCAFE0009, 16'hFFF0);
    do_update(9'd9, 32'hCAFE0009, 16'hFFF0, lat, to); model_update(9, 32'hCAFE0009, 16'hFFF0);
    do_lookup(9'd9, 1, h, p, v, to);
    checks++;
    if (to || {h, p, v} !== {1'b1, 32'hCAFE0009, 16'hFFFF}) begin
      errors++; $display("FAIL saturate_lookup9: got hit=%b price=%h vol=%h required 1/cafe0009/ffff", h, p, v);
    end
  endtask

  task automatic test_back_to_back_stall();
    int n, bad_stable, bad_rdy; logic [48:0] held; logic [31:0] np; logic [15:0] nd;
    logic h; logic [31:0] p; logic [15:0] v; bit to;
    n = 0; bad_stable = 0; bad_rdy = 0;
    np = $urandom; nd = 16'($urandom_range(1, 500));
    @(negedge axis_aclk);
    lkp_valid = 1'b1; lkp_index = 9'd5; lkp_rsp_ready = 1'b0;
    #1;
    while (lkp_ready !== 1'b1 && n < 100) begin @(negedge axis_aclk); #1; n++; end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_valid = 1'b0;
    n = 0; #1;
    while (lkp_rsp_valid !== 1'b1 && n < 50) begin @(negedge axis_aclk); #1; n++; end
    held = {lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol};
    checks++;
    if (n >= 50 || held !== {m_valid[5], m_price[5], m_vol[5]}) begin
      errors++; $display("FAIL stall_rsp_value: got %h required %h", held, {m_valid[5], m_price[5], m_vol[5]});
    end
    upd_valid = 1'b1; upd_index = 9'd20; upd_price = np; upd_vol_delta = nd;
    for (int i = 0; i < 20; i++) begin
      @(negedge axis_aclk); #1;
      if ({lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol} !== held || lkp_rsp_valid !== 1'b1) bad_stable++;
      if (upd_ready !== 1'b0) bad_rdy++;
    end
    checks++;
    if (bad_stable != 0) begin errors++; $display("FAIL stall_rsp_stable: got %0d changed cycles required 0", bad_stable); end
    checks++;
    if (bad_rdy != 0) begin errors++; $display("FAIL stall_upd_ready: got %0d high cycles required 0", bad_rdy); end
    lkp_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_rsp_ready = 1'b0;
    n = 0; #1;
    while (upd_ready !== 1'b1 && n < 50) begin @(negedge axis_aclk); #1; n++; end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    upd_valid = 1'b0;
    model_update(20, np, nd);
    do_lookup(9'd20, 0, h, p, v, to);
    checks++;
    if (to || {h, p, v} !== {1'b1, np, nd}) begin
      errors++; $display("FAIL held_update_lookup20: got %h required %h", {h, p, v}, {1'b1, np, nd});
    end
  endtask

  task automatic test_clear_during_rsp();
    int n, early, nw, bad, bl; bit to; logic [48:0] got;
    n = 0; early = 0;
    @(negedge axis_aclk);
    lkp_valid = 1'b1; lkp_index = 9'd9; lkp_rsp_ready = 1'b0;
    #1;
    while (lkp_ready !== 1'b1 && n < 100) begin @(negedge axis_aclk); #1; n++; end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_valid = 1'b0;
    n = 0; #1;
    while (lkp_rsp_valid !== 1'b1 && n < 50) begin @(negedge axis_aclk); #1; n++; end
    got = {lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol};
    checks++;
    if (n >= 50 || got !== {m_valid[9], m_price[9], m_vol[9]}) begin
      errors++; $display("FAIL rsp_before_clear: got %h required %h", got, {m_valid[9], m_price[9], m_vol[9]});
    end
    pulse_clear();
    #1;
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL busy_while_pending: got %b required 1", clear_busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge axis_aclk); #1;
      if (ram_we !== 1'b0 || lkp_rsp_valid !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL clear_waits_rsp: got %0d early cycles required 0", early); end
    lkp_rsp_ready = 1'b1;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    lkp_rsp_ready = 1'b0;
    watch_clear(nw, bad, bl, to);
    check_clear_result("rspclear", nw, bad, bl, to);
    model_clear_range(0, 511);
  endtask

  task automatic test_random();
    int lat, bad_rsp, bad_miss; bit to; logic h; logic [31:0] p; logic [15:0] v;
    logic [8:0] idx; logic [31:0] np; logic [15:0] nd;
    bad_rsp = 0; bad_miss = 0;
    for (int k = 0; k < 80; k++) begin
      idx = 9'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        np = $urandom;
        nd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h8000, 16'hFFFF)) : 16'($urandom_range(0, 1000));
        do_update(idx, np, nd, lat, to);
        model_update(int'(idx), np, nd);
      end else begin
        do_lookup(idx, $urandom_range(0, 3), h, p, v, to);
        if (!m_valid[idx]) m_miss++;
        checks++;
        if (to || {h, p, v} !== {m_valid[idx], m_price[idx], m_vol[idx]}) begin
          errors++; bad_rsp++;
          $display("FAIL rand_lookup idx=%0d: got %h required %h", idx, {h, p, v}, {m_valid[idx], m_price[idx], m_vol[idx]});
        end
        checks++;
        if (lkp_miss_cnt !== m_miss) begin
          errors++; bad_miss++;
          $display("FAIL rand_miss_cnt: got %0d required %0d", lkp_miss_cnt, m_miss);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n; bit to; logic h; logic [31:0] p; logic [15:0] v; logic [15:0] nd;
    n = 0; nd = 16'($urandom_range(1, 60000));
    pulse_clear();
    #1;
    while (!(ram_we === 1'b1 && ram_addr === 9'd100) && n < 1000) begin @(negedge axis_aclk); #1; n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL reach_addr100: got timeout required addr 100"); end
    #1 axis_resetn = 1'b0;
    #1;
    checks++;
    if ({upd_ready, lkp_ready, lkp_rsp_valid, lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol,
         ram_we, ram_addr, ram_din, clear_busy, lkp_miss_cnt} !== 144'h0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %h required 0", {upd_ready, lkp_ready, lkp_rsp_valid,
               lkp_rsp_hit, lkp_rsp_price, lkp_rsp_vol, ram_we, ram_addr, ram_din, clear_busy, lkp_miss_cnt});
    end
    model_clear_range(0, 99);
    m_miss = 32'h0;
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    upd_valid = 1'b1; upd_index = 9'd3; upd_price = 32'h00ABCDEF; upd_vol_delta = nd;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_ready: got %b required 1", upd_ready); end
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    upd_valid = 1'b0;
    model_update(3, 32'h00ABCDEF, nd);
    do_lookup(9'd3, 0, h, p, v, to);
    checks++;
    if (to || {h, p, v} !== {1'b1, 32'h00ABCDEF, nd}) begin
      errors++; $display("FAIL post_reset_lookup3: got %h required %h", {h, p, v}, {1'b1, 32'h00ABCDEF, nd});
    end
    do_lookup(9'd200, 0, h, p, v, to);
    if (!m_valid[200]) m_miss++;
    checks++;
    if (to || {h, p, v} !== {m_valid[200], m_price[200], m_vol[200]} || lkp_miss_cnt !== m_miss) begin
      errors++; $display("FAIL post_reset_lookup200: got %h cnt=%0d required %h cnt=%0d",
                         {h, p, v}, lkp_miss_cnt, {m_valid[200], m_price[200], m_vol[200]}, m_miss);
    end
  endtask

  initial begin
    test_reset();
    test_clear_then_lookup();
    test_update_accumulate();
    test_saturation();
    test_back_to_back_stall();
    test_clear_during_rsp();
    test_random();
    test_reset_mid_clear();
    repeat (3) @(negedge axis_aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
